store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 4, meaning the number of buffered line-write entries (power of two, at least 2).
REQ-002 The block SHALL have the following ports; clk and rst form the only clock/reset pair:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inReq  in  1  retired store write from the store committer.
- inAddr  in  PHY_ADDR_WIDTH  physical address, line-aligned.
- inData  in  DCACHE_LINE_WIDTH  write line data.
- inByteWE  in  DCACHE_LINE_BYTE_NUM  byte enables.
- inUncachable  in  1  uncachable write.
- inAck  out  1  write accepted this cycle.
- dcWriteReq  out  1  head write request to the DCache.
- dcWriteAddr  out  PHY_ADDR_WIDTH  head address.
- dcWriteData  out  DCACHE_LINE_WIDTH  head data.
- dcWriteByteWE  out  DCACHE_LINE_BYTE_NUM  head byte enables.
- dcWriteUncachable  out  1  head uncachable flag.
- dcWriteReqAck  in  1  DCache took the head request.
- bufferEmpty  out  1  no valid entries; used for fences and recovery.
- bufferCount  out  clog2(ENTRY_NUM)+1  number of valid entries.

Function
REQ-003 The entries SHALL form a circular FIFO with head pointer, tail pointer and count registers; pointers wrap modulo ENTRY_NUM.
REQ-004 An input SHALL merge when all of these hold: inReq=1, inUncachable=0, and a valid, unlocked, cachable entry exists with an equal address.
REQ-005 A merge SHALL write inData bytes where inByteWE=1 into that entry and OR inByteWE into its byte enables; the count SHALL NOT change.
REQ-006 A non-merging input SHALL allocate the tail entry when count<ENTRY_NUM, then the tail SHALL increment.
REQ-007 inAck SHALL be combinational and equal to (merge or count<ENTRY_NUM) while inReq=1, and 0 when inReq=0.
REQ-008 When the buffer is full, an input SHALL be refused even in a cycle that pops the head; a merge SHALL still be accepted.
REQ-009 dcWriteReq SHALL equal (count>0). The dcWrite* outputs SHALL be driven from the head entry.
REQ-010 The head entry SHALL become locked in any cycle where dcWriteReq=1, and SHALL NOT be merged into while locked; its outputs SHALL stay stable until acknowledged.
REQ-011 When dcWriteReq=1 and dcWriteReqAck=1, the head SHALL pop at the clock edge, and the new head SHALL be presented in the next cycle.
REQ-012 Uncachable entries SHALL never be merge targets or merge sources, and SHALL drain in program order with all other entries.
REQ-013 At most one unlocked entry per cachable line SHALL exist. This is guaranteed by REQ-004 and REQ-006, and the bench SHALL check it.
REQ-014 Latency: an entry allocated at edge N SHALL be visible on dcWriteReq in the cycle after edge N; an empty buffer adds one cycle over a direct pass-through.
REQ-015 A simultaneous allocate and pop SHALL leave count unchanged and move both pointers.
REQ-016 A simultaneous merge into a non-head entry and pop SHALL decrement count by 1.
REQ-017 dcWriteReqAck while dcWriteReq=0 SHALL be ignored.

Reset
REQ-018 When rst=0, the block SHALL asynchronously clear head, tail, count and all valid and lock bits.
REQ-019 During and after reset: dcWriteReq=0, inAck=0, bufferEmpty=1, bufferCount=0.
REQ-020 Data, address and byte-enable storage need not be reset; the dcWrite* data outputs are don't-care while dcWriteReq=0.
REQ-021 Asserting reset in mid-drain SHALL discard all entries without issuing any further request.

Structure
REQ-022 StoreWriteBufferEntry (valid, lock, uncachable, addr, data, byteWE) and the index/count typedefs SHALL reside in CacheSystemTypes.
REQ-023 ENTRY_NUM's default SHALL be a constant in CacheSystemTypes.
REQ-024 The byte-merge datapath SHALL be one sub-module, store_write_buffer_merger: inputs old data/WE and new data/WE, output merged data/WE, purely combinational.
REQ-025 Address-match comparators SHALL be per-entry inside the top module.

Verification
REQ-026 Single write: inReq with addr 0x1000, WE 0x000F, ack held 0 for 3 cycles, then 1 -> dcWriteReq=1 with stable outputs for 4 cycles, pop, bufferEmpty=1.
REQ-027 Merge: two cachable writes to 0x2000, WE 0x00F0 then 0x0F00, DCache ack 0 -> count=1, head WE=0x0FF0, bytes from both writes present.
REQ-028 Locked head: write to 0x3000 while it is head with dcWriteReq=1, then a second write to 0x3000 -> new entry allocated, count=2, first request unchanged.
REQ-029 Full: 4 distinct addresses, fifth distinct write with pop in the same cycle -> inAck=0; fifth write matching an unlocked entry -> inAck=1.
REQ-030 Uncachable ordering: writes A (uncachable), B, A (uncachable) -> three entries, no merge, issued A, B, A in order.
REQ-031 Reset during drain: 3 entries, rst=0 for 1 cycle mid-request -> dcWriteReq=0 at once, count=0, no further requests.

Source files
------------

// File: rtl/store_write_buffer_pkg.sv
// Shared cache-system types for the store write buffer: bus widths,
// default entry count and the entry record.
package CacheSystemTypes;

  localparam int PHY_ADDR_WIDTH       = 32;
  localparam int DCACHE_LINE_WIDTH    = 128;
  localparam int DCACHE_LINE_BYTE_NUM = DCACHE_LINE_WIDTH / 8;

  // Default number of buffered line-write entries (power of two, >= 2).
  localparam int STORE_WRITE_BUFFER_ENTRY_NUM = 4;

  typedef logic [PHY_ADDR_WIDTH-1:0]       PhyAddrPath;
  typedef logic [DCACHE_LINE_WIDTH-1:0]    DCacheLinePath;
  typedef logic [DCACHE_LINE_BYTE_NUM-1:0] DCacheByteEnablePath;

  typedef logic [$clog2(STORE_WRITE_BUFFER_ENTRY_NUM)-1:0] StoreWriteBufferIndexPath;
  typedef logic [$clog2(STORE_WRITE_BUFFER_ENTRY_NUM):0]   StoreWriteBufferCountPath;

  typedef struct packed {
    logic                valid;
    logic                lock;
    logic                uncachable;
    PhyAddrPath          addr;
    DCacheLinePath       data;
    DCacheByteEnablePath byteWE;
  } StoreWriteBufferEntry;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store-committer and DCache-side signals of the store write buffer.
// master: committer/DCache side, slave: the buffer itself.
interface store_write_buffer_if
  import CacheSystemTypes::*;
#(
  parameter int ENTRY_NUM = STORE_WRITE_BUFFER_ENTRY_NUM
);

  logic                       inReq;
  PhyAddrPath                 inAddr;
  DCacheLinePath              inData;
  DCacheByteEnablePath        inByteWE;
  logic                       inUncachable;
  logic                       inAck;

  logic                       dcWriteReq;
  PhyAddrPath                 dcWriteAddr;
  DCacheLinePath              dcWriteData;
  DCacheByteEnablePath        dcWriteByteWE;
  logic                       dcWriteUncachable;
  logic                       dcWriteReqAck;

  logic                       bufferEmpty;
  logic [$clog2(ENTRY_NUM):0] bufferCount;

  modport master (
    output inReq, inAddr, inData, inByteWE, inUncachable, dcWriteReqAck,
    input  inAck, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
           dcWriteUncachable, bufferEmpty, bufferCount
  );

  modport slave (
    input  inReq, inAddr, inData, inByteWE, inUncachable, dcWriteReqAck,
    output inAck, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
           dcWriteUncachable, bufferEmpty, bufferCount
  );

endinterface

// File: rtl/store_write_buffer_merger.sv
// Byte-merge datapath: new bytes overwrite old bytes where enabled,
// byte enables accumulate. Purely combinational.
module store_write_buffer_merger
  import CacheSystemTypes::*;
(
  input  DCacheLinePath       i_old_data,
  input  DCacheByteEnablePath i_old_we,
  input  DCacheLinePath       i_new_data,
  input  DCacheByteEnablePath i_new_we,
  output DCacheLinePath       o_merged_data,
  output DCacheByteEnablePath o_merged_we
);

  // Select each byte from the new line when its enable is set.
  always_comb begin
    // NOTE: combinational blocks use blocking '=', and every output gets a
    // default first so no path leaves it unassigned (which would infer a latch).
    o_merged_data = i_old_data;
    o_merged_we   = i_old_we | i_new_we;
    for (int b = 0; b < DCACHE_LINE_BYTE_NUM; b++) begin
      if (i_new_we[b]) o_merged_data[b*8 +: 8] = i_new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of retired line writes. Cachable writes
// merge into a pending unlocked entry of the same line; everything drains
// to the DCache from the head in program order.
module store_write_buffer
  import CacheSystemTypes::*;
#(
  parameter int ENTRY_NUM = STORE_WRITE_BUFFER_ENTRY_NUM
) (
  input  logic                clk,
  input  logic                rst,
  store_write_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = IDX_W + 1;

  StoreWriteBufferEntry r_entry [ENTRY_NUM];
  logic [IDX_W-1:0]     r_head;
  logic [IDX_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 w_not_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_merge;
  logic                 w_alloc;
  logic [ENTRY_NUM-1:0] w_match;
  logic [IDX_W-1:0]     w_merge_idx;
  DCacheLinePath        w_merged_data;
  DCacheByteEnablePath  w_merged_we;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == CNT_W'(ENTRY_NUM));
  assign w_pop       = w_not_empty & bus.dcWriteReqAck;

  // Per-entry line comparators. A head that pops this cycle is excluded so
  // merged bytes can never be lost with the outgoing request.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_match[i] = r_entry[i].valid && !r_entry[i].lock && !r_entry[i].uncachable
                   && (r_entry[i].addr == bus.inAddr)
                   && !(w_pop && (IDX_W'(i) == r_head));
    end
  end

  // Encode the single matching entry (at most one unlocked entry per line).
  always_comb begin
    w_merge_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (w_match[i]) w_merge_idx = IDX_W'(i);
    end
  end

  assign w_merge   = bus.inReq && !bus.inUncachable && (|w_match);
  assign w_alloc   = bus.inReq && !w_merge && !w_full;
  assign bus.inAck = rst && bus.inReq && (w_merge || !w_full);

  store_write_buffer_merger u_merger (
    .i_old_data    (r_entry[w_merge_idx].data),
    .i_old_we      (r_entry[w_merge_idx].byteWE),
    .i_new_data    (bus.inData),
    .i_new_we      (bus.inByteWE),
    .o_merged_data (w_merged_data),
    .o_merged_we   (w_merged_we)
  );

  // Pointer, count and entry update: lock the presented head, merge, allocate, pop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; only control bits are reset, the line payload is not,
    // since valid gates every use of it.
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_entry[i].valid <= 1'b0;
        r_entry[i].lock  <= 1'b0;
      end
    end else begin
      if (w_not_empty) r_entry[r_head].lock <= 1'b1;

      if (w_merge) begin
        r_entry[w_merge_idx].data   <= w_merged_data;
        r_entry[w_merge_idx].byteWE <= w_merged_we;
      end

      if (w_alloc) begin
        r_entry[r_tail] <= '{valid:      1'b1,
                             lock:       1'b0,
                             uncachable: bus.inUncachable,
                             addr:       bus.inAddr,
                             data:       bus.inData,
                             byteWE:     bus.inByteWE};
        r_tail <= r_tail + IDX_W'(1);
      end

      if (w_pop) begin
        r_entry[r_head].valid <= 1'b0;
        r_entry[r_head].lock  <= 1'b0;
        r_head <= r_head + IDX_W'(1);
      end

      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.dcWriteReq        = w_not_empty;
  assign bus.dcWriteAddr       = r_entry[r_head].addr;
  assign bus.dcWriteData       = r_entry[r_head].data;
  assign bus.dcWriteByteWE     = r_entry[r_head].byteWE;
  assign bus.dcWriteUncachable = r_entry[r_head].uncachable;
  assign bus.bufferEmpty       = !w_not_empty;
  assign bus.bufferCount       = r_count;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus
// random traffic, compared against a queue-based model of the buffer.
module tb_store_write_buffer;
  import CacheSystemTypes::*;

  localparam int N = STORE_WRITE_BUFFER_ENTRY_NUM;
  typedef logic [127:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_write_buffer_if dut_if ();
  store_write_buffer dut (.clk(clk), .rst(rst), .bus(dut_if));

  // Model: a pending line write; 'locked' once it has been presented at a clock edge.
  typedef struct {
    PhyAddrPath          addr;
    DCacheLinePath       data;
    DCacheByteEnablePath we;
    bit                  unc;
    bit                  locked;
  } line_t;

  line_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit req, input PhyAddrPath addr,
                       input DCacheByteEnablePath we, input bit unc, input bit ack);
    dut_if.inReq         = req;
    dut_if.inAddr        = addr;
    dut_if.inByteWE      = we;
    dut_if.inUncachable  = unc;
    dut_if.dcWriteReqAck = ack;
    dut_if.inData        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // At most one valid, unlocked, cachable entry per line inside the buffer.
  task automatic check_unique();
    int dup;
    dup = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (dut.r_entry[i].valid && dut.r_entry[j].valid &&
            !dut.r_entry[i].lock && !dut.r_entry[j].lock &&
            !dut.r_entry[i].uncachable && !dut.r_entry[j].uncachable &&
            dut.r_entry[i].addr == dut.r_entry[j].addr)
          dup++;
    check("unique_line", val_t'(dup), val_t'(0));
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int    mi;
    bit    exp_ack;
    bit    exp_pop;
    line_t e;
    @(negedge clk);
    exp_pop = (q.size() > 0) && dut_if.dcWriteReqAck;
    mi = -1;
    if (dut_if.inReq && !dut_if.inUncachable)
      for (int k = 0; k < q.size(); k++)
        if (!q[k].locked && !q[k].unc && q[k].addr == dut_if.inAddr &&
            !(k == 0 && exp_pop))
          mi = k;
    exp_ack = dut_if.inReq && (mi >= 0 || q.size() < N);

    check("inAck", val_t'(dut_if.inAck), val_t'(exp_ack));
    check("dcWriteReq", val_t'(dut_if.dcWriteReq), val_t'(q.size() > 0));
    check("bufferEmpty", val_t'(dut_if.bufferEmpty), val_t'(q.size() == 0));
    check("bufferCount", val_t'(dut_if.bufferCount), val_t'(q.size()));
    if (q.size() > 0) begin
      check("dcWriteAddr", val_t'(dut_if.dcWriteAddr), val_t'(q[0].addr));
      check("dcWriteData", val_t'(dut_if.dcWriteData), val_t'(q[0].data));
      check("dcWriteByteWE", val_t'(dut_if.dcWriteByteWE), val_t'(q[0].we));
      check("dcWriteUncachable", val_t'(dut_if.dcWriteUncachable), val_t'(q[0].unc));
    end
    check_unique();

    @(posedge clk);
    if (q.size() > 0) q[0].locked = 1'b1;
    if (mi >= 0) begin
      e = q[mi];
      for (int b = 0; b < DCACHE_LINE_BYTE_NUM; b++)
        if (dut_if.inByteWE[b]) e.data[b*8 +: 8] = dut_if.inData[b*8 +: 8];
      e.we = e.we | dut_if.inByteWE;
      q[mi] = e;
    end else if (exp_ack) begin
      q.push_back('{addr: dut_if.inAddr, data: dut_if.inData, we: dut_if.inByteWE,
                    unc: dut_if.inUncachable, locked: 1'b0});
    end
    if (exp_pop) void'(q.pop_front());
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 4 * N;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    while (q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    check("drain_empty", val_t'(dut_if.bufferEmpty), val_t'(1));
  endtask

  // Assert reset away from the clock edge, check the asynchronous clear, hold one edge.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    check("rst_dcWriteReq", val_t'(dut_if.dcWriteReq), val_t'(0));
    check("rst_count", val_t'(dut_if.bufferCount), val_t'(0));
    check("rst_empty", val_t'(dut_if.bufferEmpty), val_t'(1));
    q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    // Reset with a request pending: nothing may be accepted or requested.
    drive(1'b1, 32'h1000, 16'hFFFF, 1'b0, 1'b1);
    #12;
    check("reset_inAck", val_t'(dut_if.inAck), val_t'(0));
    check("reset_dcWriteReq", val_t'(dut_if.dcWriteReq), val_t'(0));
    check("reset_empty", val_t'(dut_if.bufferEmpty), val_t'(1));
    check("reset_count", val_t'(dut_if.bufferCount), val_t'(0));
    @(posedge clk);
    #2 rst = 1'b1;

    // Single write held three cycles unacknowledged, then popped.
    drive(1'b1, 32'h1000, 16'h000F, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); repeat (3) step();
    drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    check("single_empty", val_t'(dut_if.bufferEmpty), val_t'(1));

    // Back-to-back merge into the same line.
    drive(1'b1, 32'h2000, 16'h00F0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2000, 16'h0F00, 1'b0, 1'b0); step();
    check("merge_count", val_t'(dut_if.bufferCount), val_t'(1));
    check("merge_we", val_t'(dut_if.dcWriteByteWE), val_t'(16'h0FF0));
    drain();

    // Locked head: a later write to the same line allocates a new entry.
    drive(1'b1, 32'h3000, 16'h0003, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h3000, 16'h0030, 1'b0, 1'b0); step();
    check("locked_count", val_t'(dut_if.bufferCount), val_t'(2));
    check("locked_we", val_t'(dut_if.dcWriteByteWE), val_t'(16'h0003));
    drain();

    // Full buffer: refused even while popping; a merge is still accepted.
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 32'h4000 + 32'(i) * 32'h100, 16'h1111, 1'b0, 1'b0); step();
    end
    drive(1'b1, 32'h4800, 16'h2222, 1'b0, 1'b1);
    #1 check("full_refuse", val_t'(dut_if.inAck), val_t'(0));
    step();
    drive(1'b1, 32'h4900, 16'h3333, 1'b0, 1'b0); step();
    drive(1'b1, 32'h4200, 16'hF000, 1'b0, 1'b1);
    #1 check("full_merge", val_t'(dut_if.inAck), val_t'(1));
    step();
    check("merge_pop_count", val_t'(dut_if.bufferCount), val_t'(N - 1));
    drain();

    // Uncachable ordering: A(unc), B, A(unc) stay separate and drain in order.
    drive(1'b1, 32'h6000, 16'h000F, 1'b1, 1'b0); step();
    drive(1'b1, 32'h6100, 16'h00F0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h6000, 16'h0F00, 1'b1, 1'b0); step();
    check("unc_count", val_t'(dut_if.bufferCount), val_t'(3));
    drain();

    // Reset in mid-drain discards everything.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5000 + 32'(i) * 32'h100, 16'hFFFF, 1'b0, 1'b0); step();
    end
    reset_mid();
    drive(1'b0, '0, '0, 1'b0, 1'b1); repeat (4) step();

    // Random traffic over a few lines to exercise merge/alloc/pop overlap.
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 3) != 0),
            32'h100 * 32'($urandom_range(1, 4)),
            16'($urandom),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) == 0));
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
